// File: rtl/multiword_add_seq.sv
// multiword_add_seq
// Drives a narrow WIDTH-bit combinational adder one chunk per cycle to add two
// CHUNKS*WIDTH-bit operands. Each chunk's carry-out is fed back as the next chunk's
// carry-in, so the wide sum completes CHUNKS cycles after start is accepted.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             request an operation (sampled only when idle)
//   op_a, op_b, cin   operands and initial carry, captured on the accepting edge
//   busy              high while chunks are being processed
//   done              one-cycle completion pulse
//   result, cout      registered wide sum and final carry-out
//   add_a/b/ci        chunk operands and carry to the external adder
//   add_sum, add_co   sum and carry back from the external adder
module multiword_add_seq #(
    parameter int unsigned WIDTH  = 6,
    parameter int unsigned CHUNKS = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [WIDTH*CHUNKS-1:0] op_a,
    input  logic [WIDTH*CHUNKS-1:0] op_b,
    input  logic                    cin,
    output logic                    busy,
    output logic                    done,
    output logic [WIDTH*CHUNKS-1:0] result,
    output logic                    cout,
    output logic [WIDTH-1:0]        add_a,
    output logic [WIDTH-1:0]        add_b,
    output logic                    add_ci,
    input  logic [WIDTH-1:0]        add_sum,
    input  logic                    add_co
);
    localparam int unsigned N     = WIDTH * CHUNKS;
    localparam int unsigned IDX_W = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(CHUNKS - 1);
    localparam logic [N-1:0]     CHUNK_MASK = {{(N-WIDTH){1'b0}}, {WIDTH{1'b1}}};

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [N-1:0]     a_reg, a_nxt;
    logic [N-1:0]     b_reg, b_nxt;
    logic [N-1:0]     result_nxt;
    logic             carry, carry_nxt;
    logic             cout_nxt;
    logic             done_nxt;
    logic [IDX_W-1:0] idx, idx_nxt;
    logic [31:0]      sh;
    logic [N-1:0]     a_shift, b_shift;

    // Bit offset of the active chunk and the chunk-aligned operand views
    assign sh      = 32'(idx) * WIDTH;
    assign a_shift = a_reg >> sh;
    assign b_shift = b_reg >> sh;

    // Adder drive: active chunk while running, quiet zeros while idle
    assign busy   = (state == RUN);
    assign add_a  = busy ? a_shift[WIDTH-1:0] : '0;
    assign add_b  = busy ? b_shift[WIDTH-1:0] : '0;
    assign add_ci = busy ? carry : 1'b0;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_reg  <= '0;
            b_reg  <= '0;
            carry  <= 1'b0;
            idx    <= '0;
            result <= '0;
            cout   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_nxt;
            a_reg  <= a_nxt;
            b_reg  <= b_nxt;
            carry  <= carry_nxt;
            idx    <= idx_nxt;
            result <= result_nxt;
            cout   <= cout_nxt;
            done   <= done_nxt;
        end
    end

    // Next-state and next-register logic
    always_comb begin
        state_nxt  = state;
        a_nxt      = a_reg;
        b_nxt      = b_reg;
        carry_nxt  = carry;
        idx_nxt    = idx;
        result_nxt = result;
        cout_nxt   = cout;
        done_nxt   = 1'b0;

        unique case (state)
            IDLE: begin
                if (start) begin
                    a_nxt      = op_a;
                    b_nxt      = op_b;
                    carry_nxt  = cin;
                    idx_nxt    = '0;
                    result_nxt = '0;
                    cout_nxt   = 1'b0;
                    state_nxt  = RUN;
                end
            end
            RUN: begin
                // Merge the adder's sum into the active chunk of the result
                result_nxt = (result & ~(CHUNK_MASK << sh)) | (N'(add_sum) << sh);
                carry_nxt  = add_co;
                idx_nxt    = idx + IDX_W'(1);
                if (idx == LAST_IDX) begin
                    cout_nxt  = add_co;
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_multiword_add_seq.sv
// Directed and random checks of multiword_add_seq attached to a behavioural 6-bit adder.
module tb_multiword_add_seq;
    localparam int unsigned WIDTH  = 6;
    localparam int unsigned CHUNKS = 4;
    localparam int unsigned N      = WIDTH * CHUNKS;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [N-1:0]     op_a, op_b;
    logic             cin;
    logic             busy, done, cout;
    logic [N-1:0]     result;
    logic [WIDTH-1:0] add_a, add_b, add_sum;
    logic             add_ci, add_co;

    int errors = 0;
    int checks = 0;

    multiword_add_seq #(.WIDTH(WIDTH), .CHUNKS(CHUNKS)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b), .cin(cin),
        .busy(busy), .done(done), .result(result), .cout(cout),
        .add_a(add_a), .add_b(add_b), .add_ci(add_ci), .add_sum(add_sum), .add_co(add_co)
    );

    // Real ripple adder stand-in
    assign {add_co, add_sum} = 7'(add_a) + 7'(add_b) + 7'(add_ci);

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic ci_log   [CHUNKS];
    int   busy_cnt;

    // One operation: start at a negedge, then sample on negedges until done.
    // lat counts edges after the accepting edge; chunk k is visible at lat=k.
    // inject_at >= 0 pulses start with other operands at that RUN cycle.
    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic c,
                          input int inject_at,
                          output logic [N-1:0] r, output logic co, output int lat);
        @(negedge clk);
        start = 1'b1; op_a = a; op_b = b; cin = c;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        busy_cnt = 0;
        while (!done && lat < 10) begin
            if (busy) busy_cnt++;
            if (lat < int'(CHUNKS)) ci_log[lat] = add_ci;
            if (lat == inject_at) begin
                start = 1'b1; op_a = 24'hABCDEF; op_b = 24'h0F0F0F; cin = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        r  = result;
        co = cout;
    endtask

    logic [N-1:0] r;
    logic         co;
    int           lat;
    int           dpulses;
    int           first_done, second_done;
    logic [N:0]   gold;
    logic [N-1:0] ra, rb;
    logic         rc;

    initial begin
        rst_n = 1'b0; start = 1'b0; op_a = '0; op_b = '0; cin = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy",   64'(busy),   64'h0);
        check("rst_done",   64'(done),   64'h0);
        check("rst_result", 64'(result), 64'h0);
        check("rst_cout",   64'(cout),   64'h0);
        check("rst_add",    64'({add_a, add_b, add_ci}), 64'h0);
        rst_n = 1'b1;

        // Full carry propagation through every chunk
        run_op(24'hFFFFFF, 24'h000001, 1'b0, -1, r, co, lat);
        check("t1_result", 64'(r),   64'h000000);
        check("t1_cout",   64'(co),  64'h1);
        check("t1_lat",    64'(lat), 64'd4);
        check("t1_busy",   64'(busy_cnt), 64'd4);
        check("t1_idle_busy", 64'(busy), 64'h0);
        check("t1_idle_add",  64'({add_a, add_b, add_ci}), 64'h0);
        @(negedge clk);
        check("t1_done_once", 64'(done), 64'h0);
        check("t1_hold",      64'({cout, result}), 64'h1000000);

        // Carry from chunk 0 into chunk 1 only
        run_op(24'h00003F, 24'h000001, 1'b0, -1, r, co, lat);
        check("t2_result", 64'(r),  64'h000040);
        check("t2_cout",   64'(co), 64'h0);
        check("t2_ci0", 64'(ci_log[0]), 64'h0);
        check("t2_ci1", 64'(ci_log[1]), 64'h1);
        check("t2_ci2", 64'(ci_log[2]), 64'h0);
        check("t2_ci3", 64'(ci_log[3]), 64'h0);

        // Initial carry-in only
        run_op(24'h000000, 24'h000000, 1'b1, -1, r, co, lat);
        check("t3_result", 64'(r),  64'h000001);
        check("t3_cout",   64'(co), 64'h0);
        check("t3_idle_add", 64'({add_a, add_b, add_ci}), 64'h0);

        // Start during RUN is ignored
        run_op(24'h123456, 24'h111111, 1'b0, 2, r, co, lat);
        check("t4_result", 64'(r),   64'h234567);
        check("t4_lat",    64'(lat), 64'd4);
        dpulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done || busy) dpulses++;
        end
        check("t4_no_requeue", 64'(dpulses), 64'd0);
        check("t4_hold",       64'(result),  64'h234567);

        // Asynchronous reset while chunk 2 is on the adder
        @(negedge clk);
        start = 1'b1; op_a = 24'h123456; op_b = 24'h111111; cin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("t5_pre_busy", 64'(busy), 64'h1);
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_busy",   64'(busy),   64'h0);
        check("t5_rst_result", 64'(result), 64'h0);
        check("t5_rst_cout",   64'({cout, done}), 64'h0);
        check("t5_rst_add",    64'({add_a, add_b, add_ci}), 64'h0);
        dpulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 2) rst_n = 1'b1;
            if (done || busy) dpulses++;
        end
        check("t5_no_done", 64'(dpulses), 64'd0);
        run_op(24'h000010, 24'h000020, 1'b0, -1, r, co, lat);
        check("t5_result", 64'(r), 64'h000030);

        // Back-to-back with start held high across done
        @(negedge clk);
        start = 1'b1; op_a = 24'h000FFF; op_b = 24'h000001; cin = 1'b0;
        first_done = -1; second_done = -1;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            if (done) begin
                if (first_done < 0) first_done = k;
                else if (second_done < 0) second_done = k;
            end
            if (k == 9) start = 1'b0;
        end
        check("t6_first",   64'(first_done),  64'd4);
        check("t6_spacing", 64'(second_done - first_done), 64'd5);
        check("t6_result",  64'(result), 64'h001000);

        // Random operands against the golden wide sum
        for (int i = 0; i < 1000; i++) begin
            ra = 24'($urandom);
            rb = 24'($urandom);
            rc = 1'($urandom);
            gold = 25'(ra) + 25'(rb) + 25'(rc);
            run_op(ra, rb, rc, -1, r, co, lat);
            check("rand_sum", 64'({co, r}), 64'(gold));
            check("rand_lat", 64'(lat), 64'd4);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no end expected end");
        $fatal(1);
    end
endmodule
